// File: rtl/bsg_counter_pkg.sv
// Shared types and constants for the up/down overflow counter.
package bsg_counter_pkg;

  typedef enum logic {
    e_counter_wrap,
    e_counter_saturate
  } bsg_counter_mode_e;

  localparam int unsigned bsg_counter_stats_width_lp = 16;

endpackage

// File: rtl/bsg_counter_next_calc.sv
// Combinational next-count and boundary-crossing logic for the up/down counter.
module bsg_counter_next_calc
  import bsg_counter_pkg::*;
#(
  parameter int unsigned           width_p      = 32,
  parameter int unsigned           step_width_p = 4,
  parameter logic [width_p-1:0]    init_val_p   = '0
) (
  input  logic [width_p-1:0]      count_i,
  input  logic [width_p-1:0]      limit_i,
  input  logic [step_width_p-1:0] step_i,
  input  logic                    up_i,
  input  bsg_counter_mode_e       mode_i,
  output logic [width_p-1:0]      next_o,
  output logic                    ovf_o,
  output logic                    unf_o
);

  logic [width_p:0] step_ext;
  logic [width_p:0] sum;

  assign step_ext = {{(width_p + 1 - step_width_p){1'b0}}, step_i};
  assign sum      = {1'b0, count_i} + step_ext;

  // A zero step always holds, even when the count already sits above the limit.
  always_comb begin
    next_o = count_i;
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    if (step_i != '0) begin
      if (up_i) begin
        if (sum > {1'b0, limit_i}) begin
          ovf_o  = 1'b1;
          next_o = (mode_i == e_counter_wrap) ? init_val_p : limit_i;
        end else begin
          next_o = sum[width_p-1:0];
        end
      end else if (step_ext > {1'b0, count_i}) begin
        unf_o  = 1'b1;
        next_o = (mode_i == e_counter_wrap) ? limit_i : '0;
      end else begin
        next_o = count_i - step_ext[width_p-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_counter_overflow_updown_en.sv
// Up/down counter with runtime limit, wrap/saturate mode and overflow/underflow pulses.
// Optional wrap statistics output enabled by BSG_COUNTER_OVERFLOW_UPDOWN_STATS_EN.
module bsg_counter_overflow_updown_en
  import bsg_counter_pkg::*;
#(
  parameter int unsigned        width_p      = 32,
  parameter int unsigned        step_width_p = 4,
  parameter logic [width_p-1:0] init_val_p   = '0,
  parameter logic [width_p-1:0] max_val_p    = '1,
  parameter int unsigned        saturate_p   = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    up_i,
  input  logic [step_width_p-1:0] step_i,
  input  logic                    set_i,
  input  logic [width_p-1:0]      val_i,
  input  logic                    limit_set_i,
  input  logic [width_p-1:0]      limit_i,
  output logic [width_p-1:0]      count_o,
  output logic [width_p-1:0]      limit_o,
  output logic                    at_limit_o,
  output logic                    overflow_o,
  output logic                    underflow_o
`ifdef BSG_COUNTER_OVERFLOW_UPDOWN_STATS_EN
  , output logic [bsg_counter_stats_width_lp-1:0] wrap_cnt_o
`endif
);

  localparam bsg_counter_mode_e mode_lp =
    (saturate_p != 0) ? e_counter_saturate : e_counter_wrap;

  if (init_val_p > max_val_p) begin : g_bad_init
    $error("init_val_p must not exceed max_val_p");
  end
  if (step_width_p > width_p) begin : g_bad_step
    $error("step_width_p must not exceed width_p");
  end

  logic [width_p-1:0] next_count;
  logic               calc_ovf;
  logic               calc_unf;

  bsg_counter_next_calc #(
    .width_p      (width_p),
    .step_width_p (step_width_p),
    .init_val_p   (init_val_p)
  ) next_calc (
    .count_i (count_o),
    .limit_i (limit_o),
    .step_i  (step_i),
    .up_i    (up_i),
    .mode_i  (mode_lp),
    .next_o  (next_count),
    .ovf_o   (calc_ovf),
    .unf_o   (calc_unf)
  );

  assign at_limit_o = (count_o == limit_o);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o     <= init_val_p;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (set_i) begin
      count_o     <= val_i;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (en_i) begin
      count_o     <= next_count;
      overflow_o  <= calc_ovf;
      underflow_o <= calc_unf;
    end else begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end
  end

  // Limit updates independently; this cycle's count decision still sees the old value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      limit_o <= max_val_p;
    end else if (limit_set_i) begin
      limit_o <= limit_i;
    end
  end

`ifdef BSG_COUNTER_OVERFLOW_UPDOWN_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrap_cnt_o <= '0;
    end else if (set_i) begin
      wrap_cnt_o <= '0;
    end else if (en_i && (calc_ovf || calc_unf) && (wrap_cnt_o != '1)) begin
      wrap_cnt_o <= wrap_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_counter_overflow_updown_en.sv
// Bench for bsg_counter_overflow_updown_en: wrap and saturate instances driven in lockstep.
module tb_bsg_counter_overflow_updown_en;
  import bsg_counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       en_i, up_i, set_i, limit_set_i;
  logic [3:0] step_i;
  logic [7:0] val_i, limit_i;

  logic [7:0] w_count, w_limit, s_count, s_limit;
  logic       w_at, w_ovf, w_unf, s_at, s_ovf, s_unf;
`ifdef BSG_COUNTER_OVERFLOW_UPDOWN_STATS_EN
  logic [15:0] w_stats, s_stats;
`endif

  always #5 clk = ~clk;

  bsg_counter_overflow_updown_en #(
    .width_p(8), .step_width_p(4), .init_val_p(8'd5), .max_val_p(8'd10), .saturate_p(0)
  ) dut_wrap (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .up_i(up_i), .step_i(step_i),
    .set_i(set_i), .val_i(val_i), .limit_set_i(limit_set_i), .limit_i(limit_i),
    .count_o(w_count), .limit_o(w_limit), .at_limit_o(w_at),
    .overflow_o(w_ovf), .underflow_o(w_unf)
`ifdef BSG_COUNTER_OVERFLOW_UPDOWN_STATS_EN
    , .wrap_cnt_o(w_stats)
`endif
  );

  bsg_counter_overflow_updown_en #(
    .width_p(8), .step_width_p(4), .init_val_p(8'd5), .max_val_p(8'd10), .saturate_p(1)
  ) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .up_i(up_i), .step_i(step_i),
    .set_i(set_i), .val_i(val_i), .limit_set_i(limit_set_i), .limit_i(limit_i),
    .count_o(s_count), .limit_o(s_limit), .at_limit_o(s_at),
    .overflow_o(s_ovf), .underflow_o(s_unf)
`ifdef BSG_COUNTER_OVERFLOW_UPDOWN_STATS_EN
    , .wrap_cnt_o(s_stats)
`endif
  );

  typedef struct {
    logic       en, up;
    logic [3:0] step;
    logic       set;
    logic [7:0] val;
    logic       lset;
    logic [7:0] lim;
    logic [7:0] wc;
    logic       wo, wu;
    logic [7:0] sc;
    logic       so, su;
    logic [7:0] el;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  vec_t        vt[24];
  vec_t        sb[$];
  vec_t        e;

  function automatic vec_t mk(input logic en, input logic up, input logic [3:0] step,
                              input logic set, input logic [7:0] val,
                              input logic lset, input logic [7:0] lim,
                              input logic [7:0] wc, input logic wo, input logic wu,
                              input logic [7:0] sc, input logic so, input logic su,
                              input logic [7:0] el);
    vec_t v;
    v.en = en; v.up = up; v.step = step; v.set = set; v.val = val;
    v.lset = lset; v.lim = lim; v.wc = wc; v.wo = wo; v.wu = wu;
    v.sc = sc; v.so = so; v.su = su; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic up, input logic [3:0] step,
                       input logic set, input logic [7:0] val,
                       input logic lset, input logic [7:0] lim);
    en_i = en; up_i = up; step_i = step; set_i = set; val_i = val;
    limit_set_i = lset; limit_i = lim;
  endtask

  initial begin
    //              en up st set val lset lim   wc wo wu  sc so su  el
    vt[0]  = mk(1, 1, 1, 0, 0,   0, 0,    6, 0, 0,  6, 0, 0, 10);
    vt[1]  = mk(1, 1, 1, 0, 0,   0, 0,    7, 0, 0,  7, 0, 0, 10);
    vt[2]  = mk(1, 1, 1, 0, 0,   0, 0,    8, 0, 0,  8, 0, 0, 10);
    vt[3]  = mk(1, 1, 1, 0, 0,   0, 0,    9, 0, 0,  9, 0, 0, 10);
    vt[4]  = mk(1, 1, 1, 0, 0,   0, 0,   10, 0, 0, 10, 0, 0, 10);
    vt[5]  = mk(1, 1, 1, 0, 0,   0, 0,    5, 1, 0, 10, 1, 0, 10);
    vt[6]  = mk(1, 1, 1, 0, 0,   0, 0,    6, 0, 0, 10, 1, 0, 10);
    vt[7]  = mk(0, 1, 0, 1, 9,   0, 0,    9, 0, 0,  9, 0, 0, 10);
    vt[8]  = mk(1, 1, 3, 0, 0,   0, 0,    5, 1, 0, 10, 1, 0, 10);
    vt[9]  = mk(1, 1, 3, 0, 0,   0, 0,    8, 0, 0, 10, 1, 0, 10);
    vt[10] = mk(0, 1, 0, 0, 0,   0, 0,    8, 0, 0, 10, 0, 0, 10);
    vt[11] = mk(0, 1, 0, 1, 2,   0, 0,    2, 0, 0,  2, 0, 0, 10);
    vt[12] = mk(1, 0, 3, 0, 0,   0, 0,   10, 0, 1,  0, 0, 1, 10);
    vt[13] = mk(0, 1, 0, 1, 0,   0, 0,    0, 0, 0,  0, 0, 0, 10);
    vt[14] = mk(1, 0, 0, 0, 0,   0, 0,    0, 0, 0,  0, 0, 0, 10);
    vt[15] = mk(1, 0, 1, 0, 0,   0, 0,   10, 0, 1,  0, 0, 1, 10);
    vt[16] = mk(0, 1, 0, 1, 7,   0, 0,    7, 0, 0,  7, 0, 0, 10);
    vt[17] = mk(1, 1, 1, 0, 0,   1, 4,    8, 0, 0,  8, 0, 0,  4);
    vt[18] = mk(1, 1, 1, 0, 0,   0, 0,    5, 1, 0,  4, 1, 0,  4);
    vt[19] = mk(1, 1, 1, 1, 200, 0, 0,  200, 0, 0, 200, 0, 0, 4);
    vt[20] = mk(1, 0, 5, 0, 0,   0, 0,  195, 0, 0, 195, 0, 0, 4);
    vt[21] = mk(0, 1, 0, 0, 0,   1, 10, 195, 0, 0, 195, 0, 0, 10);
    vt[22] = mk(0, 1, 0, 1, 10,  0, 0,   10, 0, 0, 10, 0, 0, 10);
    vt[23] = mk(1, 1, 0, 0, 0,   0, 0,   10, 0, 0, 10, 0, 0, 10);

    drive(0, 1, 0, 0, 0, 0, 0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("reset_w_count", w_count, 5);
    chk("reset_w_limit", w_limit, 10);
    chk("reset_w_ovf",   w_ovf,   0);
    chk("reset_w_unf",   w_unf,   0);
    chk("reset_s_count", s_count, 5);
    chk("reset_w_at",    w_at,    0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vt[i].en, vt[i].up, vt[i].step, vt[i].set, vt[i].val, vt[i].lset, vt[i].lim);
      sb.push_back(vt[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_w_count", i), w_count, e.wc);
      chk($sformatf("v%0d_w_ovf", i),   w_ovf,   e.wo);
      chk($sformatf("v%0d_w_unf", i),   w_unf,   e.wu);
      chk($sformatf("v%0d_w_limit", i), w_limit, e.el);
      chk($sformatf("v%0d_w_at", i),    w_at,    e.wc == e.el);
      chk($sformatf("v%0d_s_count", i), s_count, e.sc);
      chk($sformatf("v%0d_s_ovf", i),   s_ovf,   e.so);
      chk($sformatf("v%0d_s_unf", i),   s_unf,   e.su);
      chk($sformatf("v%0d_s_limit", i), s_limit, e.el);
      chk($sformatf("v%0d_s_at", i),    s_at,    e.sc == e.el);
    end

    // Overflow with a simultaneous limit change, then reset mid-cycle.
    @(negedge clk);
    drive(1, 1, 15, 0, 0, 1, 20);
    @(posedge clk);
    #1;
    chk("pre_rst_w_count", w_count, 5);
    chk("pre_rst_w_ovf",   w_ovf,   1);
    chk("pre_rst_s_count", s_count, 10);
    chk("pre_rst_limit",   w_limit, 20);
    drive(0, 1, 0, 0, 0, 0, 0);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_rst_w_count", w_count, 5);
    chk("async_rst_s_count", s_count, 5);
    chk("async_rst_w_limit", w_limit, 10);
    chk("async_rst_s_limit", s_limit, 10);
    chk("async_rst_w_ovf",   w_ovf,   0);
    chk("async_rst_s_ovf",   s_ovf,   0);
    @(negedge clk);
    reset_i = 1'b0;

`ifdef BSG_COUNTER_OVERFLOW_UPDOWN_STATS_EN
    chk("stats_reset", w_stats, 0);
    @(negedge clk);
    drive(0, 1, 0, 1, 10, 0, 0);
    @(posedge clk);
    #1;
    chk("stats_after_set", w_stats, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(1, 1, 15, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk($sformatf("stats_w_%0d", k), w_stats, k);
      chk($sformatf("stats_s_%0d", k), s_stats, k);
      chk($sformatf("stats_ovf_%0d", k), w_ovf, 1);
    end
    @(negedge clk);
    drive(0, 1, 0, 1, 3, 0, 0);
    @(posedge clk);
    #1;
    chk("stats_clear_w", w_stats, 0);
    chk("stats_clear_s", s_stats, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_counter_overflow_updown_en.md
Name: bsg_counter_overflow_updown_en

Overview:
Parametrised up/down counter with a runtime-loadable limit and selectable step size.
- Wrap or saturate mode is chosen by parameter.
- Overflow/underflow are reported as registered one-cycle pulses.
- Successor to the fixed init/max overflow counter; used for credit tracking, timers and rate dividers where the limit changes at run time.

Parameters:
- width_p, 32, counter and limit width in bits.
- step_width_p, 4, width of step_i.
- init_val_p, 0, value loaded at reset and on up-wrap.
- max_val_p, 2**width_p-1, limit register value at reset.
- saturate_p, 0, 0 = wrap mode, 1 = saturate mode.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- en_i  in  1  count enable.
- up_i  in  1  direction: 1 = add step_i, 0 = subtract step_i.
- step_i  in  step_width_p  increment/decrement amount; 0 is legal (count holds).
- set_i  in  1  load count from val_i.
- val_i  in  width_p  load value.
- limit_set_i  in  1  load limit register from limit_i.
- limit_i  in  width_p  new limit.
- count_o  out  width_p  current count (registered).
- limit_o  out  width_p  current limit (registered).
- at_limit_o  out  1  combinational, count_o == limit_o.
- overflow_o  out  1  registered pulse, up-boundary crossed last cycle.
- underflow_o  out  1  registered pulse, down-boundary crossed last cycle.

Behaviour:
- Reset (async assert, sync-safe deassert): count_o=init_val_p, limit_o=max_val_p, overflow_o=0, underflow_o=0.
- Priority per cycle: reset_i > set_i > en_i. With set_i: count<=val_i, no pulses, and en_i is ignored.
- Up count, en_i & up_i: sum = count_o + step_i computed in width_p+1 bits.
  - sum <= limit_o: count<=sum[width_p-1:0].
  - sum > limit_o, wrap mode: count<=init_val_p, overflow_o<=1.
  - sum > limit_o, saturate mode: count<=limit_o, overflow_o<=1.
- Down count, en_i & ~up_i: if step_i > count_o (would go below 0):
  - wrap mode: count<=limit_o, underflow_o<=1.
  - saturate mode: count<=0, underflow_o<=1.
  - otherwise count<=count_o-step_i.
- Pulses are asserted for exactly the cycle after the crossing edge. Back-to-back crossings give back-to-back pulses.
- Idle, ~en_i & ~set_i: count holds; pulses clear to 0.
- step_i=0 with en_i: count holds, no pulse even when count_o==limit_o.
- limit_set_i: limit_o<=limit_i at the edge.
  - The same-cycle count decision uses the old limit.
  - Independent of set_i/en_i.
- Count above limit (from set_i or a lowered limit): the next enabled up step overflows. Down counting proceeds normally.
- Latency: all outputs except at_limit_o reflect inputs one cycle later.
- Elaboration assertions: init_val_p <= max_val_p; step_width_p <= width_p.

Optional Feature:
Macro: BSG_COUNTER_OVERFLOW_UPDOWN_STATS_EN.
- Defined: adds output wrap_cnt_o [15:0].
  - Increments on every overflow_o or underflow_o event, at the same edge the pulse register is set.
  - Saturates at 16'hFFFF.
  - Cleared by reset_i and by set_i.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package bsg_counter_pkg: typedef enum bsg_counter_mode_e {e_counter_wrap, e_counter_saturate}, plus the stats width constant.
- Sub-module bsg_counter_next_calc: purely combinational next-count and crossing-flag logic. Inputs: count, limit, step, up, mode. Outputs: next value, ovf, unf.
- The top level holds the registers, set/limit priority and optional stats.

Test Plan:
- width_p=8, init_val_p=5, max_val_p=10, wrap: reset, en_i=1, up_i=1, step_i=1 for 6 cycles -> count 5..10, then 5; overflow_o high the single cycle count_o returns to 5.
- Same, saturate_p=1, step_i=3 from count 9 -> count 10, overflow_o=1 one cycle; further steps hold 10 with overflow_o pulsing each enabled cycle.
- Down, wrap, count 2, step_i=3 -> count=limit_o (10), underflow_o=1; count 0 step 0 -> hold, no pulse.
- limit_set_i with limit_i=4 while count=7 and en_i=1 up in the same cycle -> count 8 (old limit), limit_o=4; next enabled up -> count 5 (init), overflow_o=1.
- set_i=1, val_i=200, en_i=1 in the same cycle -> count 200, no pulse. Assert reset_i mid-cycle -> count 5 and limit 10 immediately, without waiting for a clock edge.
- Stats macro defined: 3 overflows, then set_i -> wrap_cnt_o 0,1,2,3, then 0.
